systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 181 ++++++++++++++++++
 tb/tb_systolic_feeder.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Streams weight tiles then activation rows from SRAM into an N_SIZE systolic array, one k-tile at a time.
// Optional busy-cycle counter enabled by defining SYSTOLIC_FEEDER_PERF_EN.
module systolic_feeder #(
   parameter int DATAWIDTH  = 8,
   parameter int N_SIZE     = 32,
   parameter int BUS_WIDTH  = 256,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] num_rows,
   input  logic [7:0]            num_ktiles,
   output logic                  act_rd_en,
   output logic [ADDR_WIDTH-1:0] act_rd_addr,
   input  logic [BUS_WIDTH-1:0]  act_rd_data,
   output logic                  wt_rd_en,
   output logic [ADDR_WIDTH-1:0] wt_rd_addr,
   input  logic [BUS_WIDTH-1:0]  wt_rd_data,
   output logic [BUS_WIDTH-1:0]  in_A,
   output logic [BUS_WIDTH-1:0]  weights,
   output logic                  valid_in,
   output logic                  load_weight,
   output logic                  first_iteration,
   output logic                  last_tile,
   input  logic                  sa_ready,
   input  logic                  sa_done,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           perf_cycles
);

   if (BUS_WIDTH != N_SIZE * DATAWIDTH) begin : g_bad_bus
      $error("systolic_feeder: BUS_WIDTH must equal N_SIZE*DATAWIDTH");
   end

   typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, WAIT_SA} state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] WLAST = ADDR_WIDTH'(N_SIZE - 1);
   localparam logic [ADDR_WIDTH-1:0] DLAST = ADDR_WIDTH'(N_SIZE - 2);

   state_t                state;
   logic [ADDR_WIDTH-1:0] rows_q;
   logic [ADDR_WIDTH-1:0] cnt;
   logic [7:0]            ktiles_q;
   logic [7:0]            ktile;
   logic [7:0]            ktile_nx;
   logic                  sa_flag;
   logic                  a_sel;
   logic [ADDR_WIDTH-1:0] wt_base_nx;
   logic [ADDR_WIDTH-1:0] act_base;

   // Products wrap modulo 2^ADDR_WIDTH by construction of the operand widths.
   always_comb begin
      ktile_nx   = ktile + 8'd1;
      wt_base_nx = ADDR_WIDTH'(ktile_nx) * ADDR_WIDTH'(N_SIZE);
      act_base   = ADDR_WIDTH'(ktile) * rows_q;
   end

   assign busy    = (state != IDLE);
   assign weights = load_weight ? wt_rd_data : '0;
   assign in_A    = a_sel ? act_rd_data : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         rows_q          <= '0;
         cnt             <= '0;
         ktiles_q        <= '0;
         ktile           <= '0;
         sa_flag         <= 1'b0;
         a_sel           <= 1'b0;
         act_rd_en       <= 1'b0;
         act_rd_addr     <= '0;
         wt_rd_en        <= 1'b0;
         wt_rd_addr      <= '0;
         valid_in        <= 1'b0;
         load_weight     <= 1'b0;
         first_iteration <= 1'b0;
         last_tile       <= 1'b0;
         done            <= 1'b0;
      end else begin
         done        <= 1'b0;
         load_weight <= wt_rd_en;
         a_sel       <= act_rd_en;
         // Drain zero rows trail the last SRAM row with no gap.
         valid_in    <= act_rd_en || (state == DRAIN);
         if (sa_done && (state == STREAM || state == DRAIN || state == WAIT_SA))
            sa_flag <= 1'b1;

         case (state)
            IDLE: begin
               if (start && sa_ready) begin
                  rows_q   <= num_rows;
                  ktiles_q <= num_ktiles;
                  ktile    <= '0;
                  if (num_rows == '0 || num_ktiles == 8'd0) begin
                     done <= 1'b1;
                  end else begin
                     state           <= WLOAD;
                     wt_rd_en        <= 1'b1;
                     wt_rd_addr      <= '0;
                     cnt             <= '0;
                     first_iteration <= 1'b1;
                     last_tile       <= (num_ktiles == 8'd1);
                  end
               end
            end
            WLOAD: begin
               if (cnt == WLAST) begin
                  wt_rd_en    <= 1'b0;
                  act_rd_en   <= 1'b1;
                  act_rd_addr <= act_base;
                  cnt         <= '0;
                  state       <= STREAM;
               end else begin
                  cnt        <= cnt + ONE;
                  wt_rd_addr <= wt_rd_addr + ONE;
               end
            end
            STREAM: begin
               if (cnt == rows_q - ONE) begin
                  act_rd_en <= 1'b0;
                  cnt       <= '0;
                  state     <= DRAIN;
               end else begin
                  cnt         <= cnt + ONE;
                  act_rd_addr <= act_rd_addr + ONE;
               end
            end
            DRAIN: begin
               if (cnt == DLAST) begin
                  cnt   <= '0;
                  state <= WAIT_SA;
               end else begin
                  cnt <= cnt + ONE;
               end
            end
            WAIT_SA: begin
               if (sa_done || sa_flag) begin
                  sa_flag <= 1'b0;
                  if (ktile == ktiles_q - 8'd1) begin
                     done            <= 1'b1;
                     state           <= IDLE;
                     first_iteration <= 1'b0;
                     last_tile       <= 1'b0;
                  end else begin
                     ktile           <= ktile_nx;
                     state           <= WLOAD;
                     wt_rd_en        <= 1'b1;
                     wt_rd_addr      <= wt_base_nx;
                     cnt             <= '0;
                     first_iteration <= 1'b0;
                     last_tile       <= (ktile_nx == ktiles_q - 8'd1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SYSTOLIC_FEEDER_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         perf_q <= '0;
      else if (state == IDLE && start && sa_ready)
         perf_q <= '0;
      else if (busy && perf_q != '1)
         perf_q <= perf_q + 32'd1;
   end

   assign perf_cycles = perf_q;
`else
   assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N_SIZE=4, DATAWIDTH=8): cycle table for a single-tile job plus multi-cycle sequences.
module tb_systolic_feeder;

   localparam int AW = 10;
   localparam int BW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] num_rows = '0;
   logic [7:0]    num_ktiles = '0;
   logic          act_rd_en, wt_rd_en;
   logic [AW-1:0] act_rd_addr, wt_rd_addr;
   logic [BW-1:0] act_rd_data = '0, wt_rd_data = '0;
   logic [BW-1:0] in_A, weights;
   logic          valid_in, load_weight, first_iteration, last_tile;
   logic          sa_ready = 1'b1, sa_done = 1'b0;
   logic          busy, done;
   logic [31:0]   perf_cycles;

   int checks = 0;
   int errors = 0;

   systolic_feeder #(.DATAWIDTH(8), .N_SIZE(4), .BUS_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .num_ktiles(num_ktiles),
      .act_rd_en(act_rd_en), .act_rd_addr(act_rd_addr), .act_rd_data(act_rd_data),
      .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
      .in_A(in_A), .weights(weights), .valid_in(valid_in), .load_weight(load_weight),
      .first_iteration(first_iteration), .last_tile(last_tile),
      .sa_ready(sa_ready), .sa_done(sa_done), .busy(busy), .done(done), .perf_cycles(perf_cycles)
   );

   always #5 clk = ~clk;

   // SRAM models: data tagged with the address it came from.
   always @(posedge clk) begin
      if (act_rd_en) act_rd_data <= 32'hA000_0000 | {22'b0, act_rd_addr};
      if (wt_rd_en)  wt_rd_data  <= 32'hB000_0000 | {22'b0, wt_rd_addr};
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wt_en"},  32'(wt_rd_en), 0);
      chk({tag, "_act_en"}, 32'(act_rd_en), 0);
      chk({tag, "_wt_a"},   32'(wt_rd_addr), 0);
      chk({tag, "_act_a"},  32'(act_rd_addr), 0);
      chk({tag, "_lw"},     32'(load_weight), 0);
      chk({tag, "_w"},      weights, 0);
      chk({tag, "_vin"},    32'(valid_in), 0);
      chk({tag, "_inA"},    in_A, 0);
      chk({tag, "_fi"},     32'(first_iteration), 0);
      chk({tag, "_lt"},     32'(last_tile), 0);
      chk({tag, "_busy"},   32'(busy), 0);
      chk({tag, "_done"},   32'(done), 0);
      chk({tag, "_perf"},   perf_cycles, 0);
   endtask

   typedef struct {
      logic          sa;
      logic          wt_en;
      logic [AW-1:0] wt_a;
      logic          lw;
      logic [31:0]   w;
      logic          act_en;
      logic [AW-1:0] act_a;
      logic          vin;
      logic [31:0]   a;
      logic          fi;
      logic          lt;
      logic          bsy;
      logic          dn;
   } vec_t;

   vec_t tv[15];

   // Single tile, num_rows=3; sa_done driven two cycles into WAIT_SA.
   task automatic run_table(input string tag);
      int bcnt = 0;
      num_rows = 10'd3; num_ktiles = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         string p;
         p = $sformatf("%s_c%0d", tag, i);
         chk({p, "_wt_en"}, 32'(wt_rd_en), 32'(tv[i].wt_en));
         if (tv[i].wt_en) chk({p, "_wt_a"}, 32'(wt_rd_addr), 32'(tv[i].wt_a));
         chk({p, "_lw"}, 32'(load_weight), 32'(tv[i].lw));
         chk({p, "_w"}, weights, tv[i].w);
         chk({p, "_act_en"}, 32'(act_rd_en), 32'(tv[i].act_en));
         if (tv[i].act_en) chk({p, "_act_a"}, 32'(act_rd_addr), 32'(tv[i].act_a));
         chk({p, "_vin"}, 32'(valid_in), 32'(tv[i].vin));
         chk({p, "_inA"}, in_A, tv[i].a);
         chk({p, "_fi"}, 32'(first_iteration), 32'(tv[i].fi));
         chk({p, "_lt"}, 32'(last_tile), 32'(tv[i].lt));
         chk({p, "_busy"}, 32'(busy), 32'(tv[i].bsy));
         chk({p, "_done"}, 32'(done), 32'(tv[i].dn));
         if (busy) bcnt++;
         sa_done = tv[i].sa;
         step();
      end
      sa_done = 1'b0;
      chk({tag, "_busy_cycles"}, bcnt, 13);
`ifdef SYSTOLIC_FEEDER_PERF_EN
      chk({tag, "_perf"}, perf_cycles, 32'(bcnt));
`else
      chk({tag, "_perf"}, perf_cycles, 0);
`endif
   endtask

   // Logs collected by run_job.
   logic [AW-1:0] wt_log[64];
   logic [1:0]    flag_log[64];
   logic [AW-1:0] act_log[16];
   logic [AW-1:0] act_start[8];
   int wt_n, act_n, st_n, done_n, done_cyc, rd_seen;

   // mode 0: pulse sa_done in WAIT_SA (after valid_in falls); mode 1: pulse at the first DRAIN cycle.
   task automatic run_job(input string tag, input int nr, input int nk, input int mode,
                          input bit spurious, input int budget);
      bit prev_v = 0, prev_a = 0, fin = 0;
      int cyc = 0;
      wt_n = 0; act_n = 0; st_n = 0; done_n = 0; done_cyc = -1; rd_seen = 0;
      num_rows = AW'(nr); num_ktiles = 8'(nk); start = 1'b1;
      step();
      start = 1'b0;
      while (!fin && cyc < budget) begin
         if (wt_rd_en) begin
            if (wt_n < 64) begin
               wt_log[wt_n] = wt_rd_addr;
               flag_log[wt_n] = {first_iteration, last_tile};
            end
            wt_n++;
         end
         if (act_rd_en) begin
            if (act_n < 16) act_log[act_n] = act_rd_addr;
            act_n++;
            if (!prev_a) begin
               if (st_n < 8) act_start[st_n] = act_rd_addr;
               st_n++;
            end
         end
         if (wt_rd_en || act_rd_en) rd_seen++;
         if (done) begin
            done_n++;
            done_cyc = cyc;
            fin = 1;
         end
         sa_done = (mode == 0) ? (prev_v && !valid_in) : (prev_a && !act_rd_en);
         if (spurious && cyc == 5) begin
            start = 1'b1; num_ktiles = 8'd1;
         end else begin
            start = 1'b0;
         end
         prev_v = valid_in;
         prev_a = act_rd_en;
         step();
         cyc++;
      end
      sa_done = 1'b0;
      start = 1'b0;
      if (!fin) begin
         errors++;
         $display("FAIL %s_timeout actual=no_done expected=done_within_%0d", tag, budget);
      end
      for (int i = 0; i < 4; i++) begin
         if (done) done_n++;
         if (wt_rd_en || act_rd_en) rd_seen++;
         step();
      end
   endtask

   initial begin
      tv[0]  = '{0, 1, 0, 0, 0,            0, 0, 0, 0,            1, 1, 1, 0};
      tv[1]  = '{0, 1, 1, 1, 32'hB0000000, 0, 0, 0, 0,            1, 1, 1, 0};
      tv[2]  = '{0, 1, 2, 1, 32'hB0000001, 0, 0, 0, 0,            1, 1, 1, 0};
      tv[3]  = '{0, 1, 3, 1, 32'hB0000002, 0, 0, 0, 0,            1, 1, 1, 0};
      tv[4]  = '{0, 0, 0, 1, 32'hB0000003, 1, 0, 0, 0,            1, 1, 1, 0};
      tv[5]  = '{0, 0, 0, 0, 0,            1, 1, 1, 32'hA0000000, 1, 1, 1, 0};
      tv[6]  = '{0, 0, 0, 0, 0,            1, 2, 1, 32'hA0000001, 1, 1, 1, 0};
      tv[7]  = '{0, 0, 0, 0, 0,            0, 0, 1, 32'hA0000002, 1, 1, 1, 0};
      tv[8]  = '{0, 0, 0, 0, 0,            0, 0, 1, 0,            1, 1, 1, 0};
      tv[9]  = '{0, 0, 0, 0, 0,            0, 0, 1, 0,            1, 1, 1, 0};
      tv[10] = '{0, 0, 0, 0, 0,            0, 0, 1, 0,            1, 1, 1, 0};
      tv[11] = '{0, 0, 0, 0, 0,            0, 0, 0, 0,            1, 1, 1, 0};
      tv[12] = '{1, 0, 0, 0, 0,            0, 0, 0, 0,            1, 1, 1, 0};
      tv[13] = '{0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 1};
      tv[14] = '{0, 0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0};

      #3;
      chk_all_zero("reset");
      #19 rst_n = 1'b1;
      step();

      run_table("job1");
      step();

      // Start while the array is not ready is ignored.
      sa_ready = 1'b0; num_rows = 10'd3; num_ktiles = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      chk("notready_busy", 32'(busy), 0);
      chk("notready_wt_en", 32'(wt_rd_en), 0);
      sa_ready = 1'b1;
      step();
      chk("notready_busy2", 32'(busy), 0);

      // Three tiles, with a spurious start mid-job.
      run_job("multi", 2, 3, 0, 1'b1, 200);
      chk("multi_wt_n", wt_n, 12);
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("multi_wt_a%0d", i), 32'(wt_log[i]), i);
         chk($sformatf("multi_flags%0d", i), 32'(flag_log[i]), {30'b0, (i / 4) == 0, (i / 4) == 2});
      end
      chk("multi_act_n", act_n, 6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("multi_act_a%0d", i), 32'(act_log[i]), i);
      chk("multi_done_n", done_n, 1);

      // sa_done arrives during DRAIN; WAIT_SA exits at once.
      run_job("early_sa", 3, 1, 1, 1'b0, 100);
      chk("early_sa_done_cyc", done_cyc, 11);
      chk("early_sa_done_n", done_n, 1);
      chk("early_sa_idle", 32'(busy), 0);

      // Zero-sized jobs finish immediately without reads.
      run_job("zero_kt", 3, 0, 0, 1'b0, 20);
      chk("zero_kt_done_cyc", done_cyc, 0);
      chk("zero_kt_reads", rd_seen, 0);
      chk("zero_kt_done_n", done_n, 1);
      run_job("zero_rows", 0, 2, 0, 1'b0, 20);
      chk("zero_rows_done_cyc", done_cyc, 0);
      chk("zero_rows_reads", rd_seen, 0);

      // Act base address product wraps modulo 1024: tile 2 starts at 1200-1024.
      run_job("wrap", 600, 3, 0, 1'b0, 3000);
      chk("wrap_tiles", st_n, 3);
      chk("wrap_start0", 32'(act_start[0]), 0);
      chk("wrap_start1", 32'(act_start[1]), 600);
      chk("wrap_start2", 32'(act_start[2]), 176);
      chk("wrap_done_n", done_n, 1);

      // Asynchronous reset at the second STREAM cycle.
      num_rows = 10'd3; num_ktiles = 8'd1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk("pre_rst_act_en", 32'(act_rd_en), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_all_zero("midrst");
      #10;
      chk("midrst_hold_busy", 32'(busy), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("postrst_done%0d", i), 32'(done), 0);
         chk($sformatf("postrst_busy%0d", i), 32'(busy), 0);
      end
      run_table("job2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
